// File: rtl/bfp_block_normalizer_if.sv
// Stream bundle for bfp_block_normalizer: input beats, normalised output beats and group exponents.
// Optional BFP_BLOCK_CNT_EN adds the block_cnt output.
interface bfp_block_normalizer_if #(
  parameter int unsigned DATA  = 16,
  parameter int unsigned ARRAY = 16
);
  localparam int unsigned IDX_W = 5;

  logic                             valid_in;
  logic                             ready_in;
  logic [ARRAY-1:0][DATA-1:0]       re_in;
  logic [ARRAY-1:0][DATA-1:0]       im_in;
  logic                             valid_out;
  logic                             ready_out;
  logic [ARRAY-1:0][DATA-1:0]       re_out;
  logic [ARRAY-1:0][DATA-1:0]       im_out;
  logic                             last_out;
  logic [IDX_W-1:0]                 index_0_7;
  logic [IDX_W-1:0]                 index_8_15;
`ifdef BFP_BLOCK_CNT_EN
  logic [15:0]                      block_cnt;

  modport master (
    output valid_in, re_in, im_in, ready_out,
    input  ready_in, valid_out, re_out, im_out, last_out, index_0_7, index_8_15, block_cnt
  );
  modport slave (
    input  valid_in, re_in, im_in, ready_out,
    output ready_in, valid_out, re_out, im_out, last_out, index_0_7, index_8_15, block_cnt
  );
`else
  modport master (
    output valid_in, re_in, im_in, ready_out,
    input  ready_in, valid_out, re_out, im_out, last_out, index_0_7, index_8_15
  );
  modport slave (
    input  valid_in, re_in, im_in, ready_out,
    output ready_in, valid_out, re_out, im_out, last_out, index_0_7, index_8_15
  );
`endif
endinterface

// File: rtl/bfp_block_normalizer.sv
// Block-floating-point encoder: buffers BEATS vectors, finds per-group headroom, replays them left-shifted.
// Optional BFP_BLOCK_CNT_EN adds a wrapping count of drained blocks.
module bfp_block_normalizer #(
  parameter int unsigned DATA  = 16,
  parameter int unsigned ARRAY = 16,
  parameter int unsigned BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  bfp_block_normalizer_if.slave   bus
);
  localparam int unsigned IDX_W = 5;
  localparam int unsigned GRP   = ARRAY / 2;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DATA - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef logic [ARRAY-1:0][DATA-1:0] vec_t;
  typedef enum logic {FILL, DRAIN} state_t;

  // Redundant sign bits: run of bits below the MSB that match it.
  function automatic logic [IDX_W-1:0] cls(input logic [DATA-1:0] x);
    logic [IDX_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = DATA - 2; i >= 0; i--) begin
      run = run & (x[i] == x[DATA-1]);
      n   = n + IDX_W'(run);
    end
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] min2(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic vec_t shift_vec(input vec_t v, input logic [IDX_W-1:0] s_lo,
                                     input logic [IDX_W-1:0] s_hi);
    vec_t r;
    for (int unsigned l = 0; l < ARRAY; l++)
      r[l] = (l < GRP) ? (v[l] << s_lo) : (v[l] << s_hi);
    return r;
  endfunction

  vec_t             buf_re [BEATS];
  vec_t             buf_im [BEATS];
  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, rd_cnt_q, rd_cnt_d, rd_sel;
  logic [IDX_W-1:0] min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic [IDX_W-1:0] idx_lo_d, idx_hi_d, blk_min_lo, blk_min_hi, sh_lo, sh_hi;
  logic             in_hs, out_hs, load_out, last_d, valid_out_d, ready_in_d;
  vec_t             re_out_d, im_out_d;

  assign in_hs  = bus.valid_in  & bus.ready_in;
  assign out_hs = bus.valid_out & bus.ready_out;

  // Running minimum including the beat currently on the input.
  always_comb begin
    blk_min_lo = min_lo_q;
    blk_min_hi = min_hi_q;
    for (int unsigned l = 0; l < ARRAY; l++) begin
      if (l < GRP) blk_min_lo = min2(blk_min_lo, min2(cls(bus.re_in[l]), cls(bus.im_in[l])));
      else         blk_min_hi = min2(blk_min_hi, min2(cls(bus.re_in[l]), cls(bus.im_in[l])));
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    min_lo_d    = min_lo_q;
    min_hi_d    = min_hi_q;
    idx_lo_d    = bus.index_0_7;
    idx_hi_d    = bus.index_8_15;
    load_out    = 1'b0;
    rd_sel      = rd_cnt_q;
    sh_lo       = bus.index_0_7;
    sh_hi       = bus.index_8_15;
    last_d      = bus.last_out;
    valid_out_d = bus.valid_out;
    ready_in_d  = bus.ready_in;
    case (state_q)
      FILL: begin
        if (in_hs) begin
          if (beat_cnt_q == LAST_BEAT) begin
            // New exponents apply straight to beat 0, which is already buffered.
            state_d     = DRAIN;
            beat_cnt_d  = '0;
            min_lo_d    = IDX_MAX;
            min_hi_d    = IDX_MAX;
            idx_lo_d    = blk_min_lo;
            idx_hi_d    = blk_min_hi;
            load_out    = 1'b1;
            rd_sel      = '0;
            sh_lo       = blk_min_lo;
            sh_hi       = blk_min_hi;
            last_d      = 1'b0;
            valid_out_d = 1'b1;
            ready_in_d  = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            min_lo_d   = blk_min_lo;
            min_hi_d   = blk_min_hi;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (bus.last_out) begin
            state_d     = FILL;
            rd_cnt_d    = '0;
            last_d      = 1'b0;
            valid_out_d = 1'b0;
            ready_in_d  = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            rd_sel   = rd_cnt_q + CNT_W'(1);
            load_out = 1'b1;
            last_d   = (rd_sel == LAST_BEAT);
          end
        end
      end
      default: state_d = FILL;
    endcase
    re_out_d = load_out ? shift_vec(buf_re[rd_sel], sh_lo, sh_hi) : bus.re_out;
    im_out_d = load_out ? shift_vec(buf_im[rd_sel], sh_lo, sh_hi) : bus.im_out;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= FILL;
      beat_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      min_lo_q       <= IDX_MAX;
      min_hi_q       <= IDX_MAX;
      bus.index_0_7  <= '0;
      bus.index_8_15 <= '0;
      bus.re_out     <= '0;
      bus.im_out     <= '0;
      bus.last_out   <= 1'b0;
      bus.valid_out  <= 1'b0;
      bus.ready_in   <= 1'b1;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      min_lo_q       <= min_lo_d;
      min_hi_q       <= min_hi_d;
      bus.index_0_7  <= idx_lo_d;
      bus.index_8_15 <= idx_hi_d;
      bus.re_out     <= re_out_d;
      bus.im_out     <= im_out_d;
      bus.last_out   <= last_d;
      bus.valid_out  <= valid_out_d;
      bus.ready_in   <= ready_in_d;
    end
  end

  // Block storage; a drain only ever reads slots written during the same block.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_re[beat_cnt_q] <= bus.re_in;
      buf_im[beat_cnt_q] <= bus.im_in;
    end
  end

`ifdef BFP_BLOCK_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      bus.block_cnt <= '0;
    else if (out_hs && bus.last_out) bus.block_cnt <= bus.block_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/bfp_block_normalizer.md
Name: bfp_block_normalizer

Overview:
Block-floating-point encoder placed ahead of the FFT butterfly stages. It buffers one block of BEATS input vectors and finds the smallest count of redundant sign bits over re and im in each lane group (lanes 0-7 and lanes 8-15). It then replays the block, left-shifted per group, and outputs the applied shift as a 5-bit index per group. These indices are the index1_0_7 / index1_8_15 exponents that the downstream de-normalising shifter consumes.

Parameters:
DATA, 16, sample width in bits (input and output, signed); 5-bit index requires DATA <= 32
ARRAY, 16, lanes per beat; must be 16 (two fixed groups of 8)
BEATS, 4, beats per block; >= 2

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
valid_in  input  1  input beat valid
ready_in  output  1  block accepts input beat
re_in  input  DATA x ARRAY  signed real samples
im_in  input  DATA x ARRAY  signed imaginary samples
valid_out  output  1  output beat valid
ready_out  input  1  downstream accepts output beat
re_out  output  DATA x ARRAY  normalised real samples
im_out  output  DATA x ARRAY  normalised imaginary samples
last_out  output  1  final beat of block
index_0_7  output  5  left shift applied to lanes 0-7
index_8_15  output  5  left shift applied to lanes 8-15

Behaviour:
- Redundant sign bit count cls(x) = number of bits below the MSB that equal the MSB, range 0..DATA-1. cls(0) = cls(-1) = DATA-1.
- Group minimum = min cls over re and im of all 8 lanes across all BEATS beats of the block.
- FSM has two states.
  - FILL: ready_in=1, valid_out=0. Each handshake (valid_in & ready_in) writes the beat into buffer slot beat_cnt, updates both running minimums and increments beat_cnt. The running minimums start at DATA-1 for each block.
  - When the beat_cnt=BEATS-1 handshake occurs: latch the final minimums into index_0_7 / index_8_15, reset beat_cnt to 0, go to DRAIN.
  - DRAIN: ready_in=0, valid_out=1. re_out/im_out = buffer[rd_cnt] <<< group index, registered. last_out=1 when rd_cnt=BEATS-1.
  - Each handshake (valid_out & ready_out) advances rd_cnt. The beat with last_out=1 returns the FSM to FILL and resets rd_cnt.
- Output data and last_out hold stable while valid_out=1 & ready_out=0. Indices hold stable for the whole drain and until the next block latches.
- Latency: first output beat valid in the cycle after the last input handshake. In FILL, ready_in does not depend on ready_out. No overlap: the next block's first beat is accepted in the cycle after the last output handshake.
- The left shift never overflows because index <= cls for every sample. All-zero group: index = DATA-1, data 0.
- valid_in while ready_in=0 is ignored (not stored).
- Reset (any time, including mid-fill or mid-drain): FSM=FILL, counters 0, valid_out=0, last_out=0, re_out/im_out=0, index_0_7=index_8_15=0; partial block discarded.

Optional Feature:
BFP_BLOCK_CNT_EN
- Defined: adds output port block_cnt [15:0], reset 0. It increments on each last_out handshake and wraps 65535 -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then 4 beats of all-zero -> index_0_7=15, index_8_15=15, 4 output beats all 0, last_out on beat 3 only.
- Lane 0 re=0x0100 (all other samples 0), lanes 8-15 all im=0xFFC0 -> index_0_7=6 and lane0 re_out=0x4000; index_8_15=9 and im_out=0x8000.
- Beat 2 lane 3 re=0x7FFF, rest small -> index_0_7=0, lanes 0-7 passed unchanged; lanes 8-15 independently normalised.
- ready_out held 0 for 5 cycles mid-drain -> outputs/indices stable, ready_in=0, no beat lost or duplicated.
- Back-to-back blocks with valid_in always 1 -> first input of block 2 accepted in the cycle after block 1's last output handshake; indices update only at block 2 latch.
- Assert rstn low after 2 input beats -> all outputs 0, then a fresh 4-beat block normalises correctly with no stale data.
